// File: rtl/axi_master_arbiter.sv
// Two-master AXI4 arbiter: IFU (m0, read-only) and LSU (m1, read/write) share one
// downstream master port, one transaction at a time; writes win at IDLE, reads round-robin.
module axi_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // m0: instruction fetch, read only
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic [3:0]            m0_arid,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic [3:0]            m0_rid,
    // m1: load/store
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic [3:0]            m1_arid,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic [3:0]            m1_rid,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic [3:0]            m1_awid,
    input  logic [7:0]            m1_awlen,
    input  logic [2:0]            m1_awsize,
    input  logic [1:0]            m1_awburst,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wlast,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [1:0]            m1_bresp,
    output logic [3:0]            m1_bid,
    // downstream master
    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_W-1:0]     io_master_araddr,
    output logic [3:0]            io_master_arid,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    input  logic                  io_master_rlast,
    input  logic [3:0]            io_master_rid,
    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic [3:0]            io_master_awid,
    output logic [7:0]            io_master_awlen,
    output logic [2:0]            io_master_awsize,
    output logic [1:0]            io_master_awburst,
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    output logic                  io_master_wlast,
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [1:0]            io_master_bresp,
    input  logic [3:0]            io_master_bid
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t r_state, w_state_nxt;
    logic   r_gnt, w_gnt_nxt;
    logic   r_last_rd, w_last_rd_nxt;
    logic   r_addr_done, w_addr_done_nxt;
    logic   r_w_done, w_w_done_nxt;

    logic w_in_rd, w_in_wr;
    logic w_sel_arvalid, w_sel_rready;
    logic w_ar_fwd, w_aw_fwd, w_w_fwd;
    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

    // Payloads pass straight through; only valid/ready are gated.
    assign io_master_araddr  = r_gnt ? m1_araddr  : m0_araddr;
    assign io_master_arid    = r_gnt ? m1_arid    : m0_arid;
    assign io_master_arlen   = r_gnt ? m1_arlen   : m0_arlen;
    assign io_master_arsize  = r_gnt ? m1_arsize  : m0_arsize;
    assign io_master_arburst = r_gnt ? m1_arburst : m0_arburst;
    assign io_master_awaddr  = m1_awaddr;
    assign io_master_awid    = m1_awid;
    assign io_master_awlen   = m1_awlen;
    assign io_master_awsize  = m1_awsize;
    assign io_master_awburst = m1_awburst;
    assign io_master_wdata   = m1_wdata;
    assign io_master_wstrb   = m1_wstrb;
    assign io_master_wlast   = m1_wlast;

    assign m0_rdata = io_master_rdata;
    assign m0_rresp = io_master_rresp;
    assign m0_rlast = io_master_rlast;
    assign m0_rid   = io_master_rid;
    assign m1_rdata = io_master_rdata;
    assign m1_rresp = io_master_rresp;
    assign m1_rlast = io_master_rlast;
    assign m1_rid   = io_master_rid;
    assign m1_bresp = io_master_bresp;
    assign m1_bid   = io_master_bid;

    assign w_in_rd       = (r_state == RD);
    assign w_in_wr       = (r_state == WR);
    assign w_sel_arvalid = r_gnt ? m1_arvalid : m0_arvalid;
    assign w_sel_rready  = r_gnt ? m1_rready  : m0_rready;
    assign w_ar_fwd      = w_in_rd & ~r_addr_done;
    assign w_aw_fwd      = w_in_wr & ~r_addr_done;
    assign w_w_fwd       = w_in_wr & ~r_w_done;
    assign w_ar_hs       = w_ar_fwd & w_sel_arvalid & io_master_arready;
    assign w_r_hs        = w_in_rd & io_master_rvalid & w_sel_rready;
    assign w_aw_hs       = w_aw_fwd & m1_awvalid & io_master_awready;
    assign w_w_hs        = w_w_fwd & m1_wvalid & io_master_wready;
    assign w_b_hs        = w_in_wr & io_master_bvalid & m1_bready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_gnt       <= 1'b0;
            r_last_rd   <= 1'b1;
            r_addr_done <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_last_rd   <= w_last_rd_nxt;
            r_addr_done <= w_addr_done_nxt;
            r_w_done    <= w_w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_nxt         = r_gnt;
        w_last_rd_nxt     = r_last_rd;
        w_addr_done_nxt   = r_addr_done;
        w_w_done_nxt      = r_w_done;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        m0_arready        = 1'b0;
        m0_rvalid         = 1'b0;
        m1_arready        = 1'b0;
        m1_rvalid         = 1'b0;
        m1_awready        = 1'b0;
        m1_wready         = 1'b0;
        m1_bvalid         = 1'b0;

        case (r_state)
            IDLE: begin
                // Requests are only sampled here; nothing handshakes in IDLE.
                if (m1_awvalid) begin
                    w_state_nxt = WR;
                    w_gnt_nxt   = 1'b1;
                end else if (m0_arvalid && m1_arvalid) begin
                    w_state_nxt = RD;
                    w_gnt_nxt   = ~r_last_rd;
                end else if (m0_arvalid) begin
                    w_state_nxt = RD;
                    w_gnt_nxt   = 1'b0;
                end else if (m1_arvalid) begin
                    w_state_nxt = RD;
                    w_gnt_nxt   = 1'b1;
                end
            end
            RD: begin
                io_master_arvalid = w_ar_fwd & w_sel_arvalid;
                m0_arready        = w_ar_fwd & ~r_gnt & io_master_arready;
                m1_arready        = w_ar_fwd &  r_gnt & io_master_arready;
                io_master_rready  = w_sel_rready;
                m0_rvalid         = ~r_gnt & io_master_rvalid;
                m1_rvalid         =  r_gnt & io_master_rvalid;
                if (w_ar_hs)
                    w_addr_done_nxt = 1'b1;
                if (w_r_hs && io_master_rlast) begin
                    w_last_rd_nxt   = r_gnt;
                    w_addr_done_nxt = 1'b0;
                    w_w_done_nxt    = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            WR: begin
                io_master_awvalid = w_aw_fwd & m1_awvalid;
                m1_awready        = w_aw_fwd & io_master_awready;
                io_master_wvalid  = w_w_fwd & m1_wvalid;
                m1_wready         = w_w_fwd & io_master_wready;
                io_master_bready  = m1_bready;
                m1_bvalid         = io_master_bvalid;
                if (w_aw_hs)
                    w_addr_done_nxt = 1'b1;
                if (w_w_hs && m1_wlast)
                    w_w_done_nxt = 1'b1;
                if (w_b_hs) begin
                    w_addr_done_nxt = 1'b0;
                    w_w_done_nxt    = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/axi_master_arbiter.md
# axi_master_arbiter

Arbitrates the core's single AXI4 memory master port between the instruction-fetch unit (m0, read-only, burst-capable) and the load/store unit (m1, read and write). Sits inside the core between IFU/LSU and the `io_master_*` pins that drive the memory/peripheral slave. Only one transaction is in flight downstream at a time. Reads use round-robin between m0 and m1. Writes from m1 take priority over reads.

## Interface
Parameters:
- ADDR_W, 32, address width on all channels
- DATA_W, 32, data width; wstrb is DATA_W/8

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- m0_arvalid/m0_arready  in/out  1/1  IFU read-address handshake
- m0_araddr/m0_arid/m0_arlen/m0_arsize/m0_arburst  in  32/4/8/3/2  IFU read-address payload
- m0_rvalid/m0_rready  out/in  1/1  IFU read-data handshake
- m0_rdata/m0_rresp/m0_rlast/m0_rid  out  32/2/1/4  IFU read-data payload
- m1_ar*, m1_r*  same set as m0  LSU read channels
- m1_awvalid/m1_awready  in/out  1/1  LSU write-address handshake
- m1_awaddr/m1_awid/m1_awlen/m1_awsize/m1_awburst  in  32/4/8/3/2  LSU write-address payload
- m1_wvalid/m1_wready  in/out  1/1  LSU write-data handshake
- m1_wdata/m1_wstrb/m1_wlast  in  32/4/1  LSU write-data payload
- m1_bvalid/m1_bready  out/in  1/1  LSU write-response handshake
- m1_bresp/m1_bid  out  2/4  LSU write-response payload
- io_master_ar*, r*, aw*, w*, b*  full AXI4 master, directions mirrored (valid out, ready in on AR/AW/W; valid in, ready out on R/B)

## Operation
- FSM states: IDLE, RD, WR. Registers: `state`, `gnt` (0=m0, 1=m1), `last_rd` (last read grantee), `addr_done` (AR/AW accepted), `w_done` (W accepted with wlast).
- IDLE: all downstream valids and all upstream readys/valids are 0. Requests are sampled, not handshaken:
  - If m1_awvalid, go to WR (gnt=1).
  - Else if exactly one arvalid, go to RD with that master.
  - Else if both arvalid, go to RD with the master ≠ last_rd.
- RD: the granted master's AR is routed combinationally to io_master_ar*; the other master sees arready=0.
  - On AR handshake, set addr_done and force io_master_arvalid to 0 afterwards.
  - io_master_r* is routed to the granted master only; the non-granted master sees rvalid=0.
  - On rvalid&rready&rlast: set last_rd=gnt, clear flags, go to IDLE.
  - R beats arriving before the AR handshake do not occur; the design does not handle them.
- WR: m1 AW and W are routed combinationally to the downstream AW and W, independently.
  - AW handshake sets addr_done and gates awvalid off.
  - W beats pass through. The beat with wlast that handshakes sets w_done and gates wvalid off.
  - io_master_b* is routed to m1.
  - On bvalid&bready: clear flags and go to IDLE.
- Payload fields (addr, id, len, size, burst, data, strb, resp, rid, bid) pass through unmodified. Only valid/ready are gated.
- A master that drops valid before its handshake is a protocol violation; behaviour is undefined.

## Timing
- Reset (asynchronous, active low) forces state=IDLE, gnt=0, last_rd=1 (m0 wins the first tie), and flags=0. All valid/ready outputs are 0 during and immediately after reset.
- Reset asserted mid-transaction aborts to IDLE at once. Outstanding downstream beats are dropped; the downstream slave is reset in the same domain.
- Arbitration costs exactly one cycle: a request seen in IDLE at cycle N has io_master_*valid=1 at cycle N+1.
- Forwarding in RD/WR is combinational. There is zero added latency per beat. R and B backpressure propagate in the same cycle.
- Back-to-back transactions: IDLE is re-entered on the cycle after the final R/B handshake, so the minimum gap between downstream transactions is 1 cycle.
- Starvation bound: with both masters reading continuously, grants strictly alternate m0, m1, m0, and so on.
- Write priority holds only at IDLE entry. An in-progress read is never preempted.

## Test plan
- Single m0 read: araddr=0x8000_0000, arlen=0, arburst=1 → downstream arvalid 1 cycle after the request. m0 receives rdata with rlast=1. m1_rvalid stays 0 throughout.
- m0 burst: arlen=3 → 4 R beats delivered to m0 in order. Insert m0_rready=0 for 2 cycles mid-burst → io_master_rready=0 in those cycles and no beat is lost.
- Simultaneous m0/m1 reads, repeated 4 times after reset → grant order m0, m1, m0, m1. Each returns its own rdata.
- m1 write: awaddr=0x8000_0100, wdata=0xDEADBEEF, wstrb=0xF, issued in the same cycle as an m0 read → write is granted first and bresp=0 is returned to m1. The m0 read is granted in the cycle after the B handshake.
- Reset pulse (low, 1 cycle) while RD is waiting for R → all outputs 0 immediately. The next m1 read request is granted normally.
- AW accepted several cycles before W (slave holds wready=0) → awvalid drops after its handshake, W is still forwarded, and the state stays WR until B.
